// File: rtl/uart_baud_gen_if.sv
// Control and tick bundle between the CSR side (master) and the baud generator (slave).
// The CSR side supplies the divisor and strobes. The generator returns the oversample tick, the baud tick and the phase.
interface uart_baud_gen_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OSR    = 16
);
  localparam int PH_W = $clog2(OSR);

  logic              i_en;
  logic              i_load;
  logic [DIV_W-1:0]  i_div_int;
  logic [FRAC_W-1:0] i_div_frac;
  logic              o_tick_os;
  logic              o_tick_baud;
  logic [PH_W-1:0]   o_phase;

  modport master (
    output i_en, i_load, i_div_int, i_div_frac,
    input  o_tick_os, o_tick_baud, o_phase
  );

  modport slave (
    input  i_en, i_load, i_div_int, i_div_frac,
    output o_tick_os, o_tick_baud, o_phase
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Fractional baud-rate tick generator: an oversample tick every div_int(+carry) clocks
// and a baud tick on every OSR-th oversample tick. The divisor is shadowed until a load strobe.
module uart_baud_gen #(
  parameter int DIV_W   = 16,
  parameter int FRAC_W  = 4,
  parameter int OSR     = 16,
  parameter int RST_DIV = 27
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  uart_baud_gen_if.slave bus
);
  localparam int                PH_W    = $clog2(OSR);
  localparam logic [PH_W-1:0]   PH_LAST = PH_W'(OSR - 1);
  localparam logic [PH_W-1:0]   PH_ONE  = PH_W'(1);
  localparam logic [DIV_W-1:0]  DIV_RST = DIV_W'(RST_DIV);
  localparam logic [DIV_W:0]    CNT_ONE = {{DIV_W{1'b0}}, 1'b1};

  logic [DIV_W-1:0]  div_int_reg,  div_int_next;
  logic [FRAC_W-1:0] div_frac_reg, div_frac_next;
  logic [DIV_W:0]    cnt_reg,      cnt_next;
  logic [FRAC_W-1:0] acc_reg,      acc_next;
  logic              carry_reg,    carry_next;
  logic [PH_W-1:0]   phase_reg,    phase_next;
  logic              tick_os_reg,  tick_os_next;
  logic              tick_baud_reg, tick_baud_next;

  logic [DIV_W:0]    div_eff;
  logic [DIV_W:0]    cnt_last;
  logic [FRAC_W:0]   frac_sum;
  logic              period_done;
  logic              phase_wrap;

  // The counter is one bit wider than the divisor so that a full-scale divisor plus carry still fits.
  always_comb begin
    div_eff     = (div_int_reg == '0) ? CNT_ONE : {1'b0, div_int_reg};
    cnt_last    = div_eff - CNT_ONE + {{DIV_W{1'b0}}, carry_reg};
    period_done = (cnt_reg == cnt_last);
    frac_sum    = {1'b0, acc_reg} + {1'b0, div_frac_reg};
    phase_wrap  = (phase_reg == PH_LAST);
  end

  always_comb begin
    div_int_next   = div_int_reg;
    div_frac_next  = div_frac_reg;
    cnt_next       = cnt_reg;
    acc_next       = acc_reg;
    carry_next     = carry_reg;
    phase_next     = phase_reg;
    tick_os_next   = 1'b0;
    tick_baud_next = 1'b0;

    if (bus.i_load) begin
      div_int_next  = bus.i_div_int;
      div_frac_next = bus.i_div_frac;
      cnt_next      = '0;
      acc_next      = '0;
      carry_next    = 1'b0;
      phase_next    = '0;
    end else if (bus.i_en) begin
      if (period_done) begin
        cnt_next       = '0;
        tick_os_next   = 1'b1;
        // The carry out of the phase accumulator stretches the next period by one clock.
        {carry_next, acc_next} = frac_sum;
        phase_next     = phase_wrap ? '0 : phase_reg + PH_ONE;
        tick_baud_next = phase_wrap;
      end else begin
        cnt_next = cnt_reg + CNT_ONE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      div_int_reg   <= DIV_RST;
      div_frac_reg  <= '0;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      carry_reg     <= 1'b0;
      phase_reg     <= '0;
      tick_os_reg   <= 1'b0;
      tick_baud_reg <= 1'b0;
    end else begin
      div_int_reg   <= div_int_next;
      div_frac_reg  <= div_frac_next;
      cnt_reg       <= cnt_next;
      acc_reg       <= acc_next;
      carry_reg     <= carry_next;
      phase_reg     <= phase_next;
      tick_os_reg   <= tick_os_next;
      tick_baud_reg <= tick_baud_next;
    end
  end

  assign bus.o_tick_os   = tick_os_reg;
  assign bus.o_tick_baud = tick_baud_reg;
  assign bus.o_phase     = phase_reg;
endmodule
